// File: rtl/qf105_wb_mailbox.sv
// rtl/qf105_wb_mailbox.sv - Wishbone mailbox with m2c/c2m word FIFOs and a user interrupt
module qf105_wb_mailbox #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] m2c_data,
    output logic        m2c_valid,
    input  logic        m2c_ready,
    input  logic [31:0] c2m_data,
    input  logic        c2m_valid,
    output logic        c2m_ready,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // FIFO storage and bookkeeping
    logic [31:0]   m2c_mem [DEPTH];
    logic [AW-1:0] m2c_wptr, m2c_rptr;
    logic [CW-1:0] m2c_count;
    logic [31:0]   c2m_mem [DEPTH];
    logic [AW-1:0] c2m_wptr, c2m_rptr;
    logic [CW-1:0] c2m_count;

    // Sticky error flags and interrupt enables
    logic ovf, unf, rxie, txie;

    // Bus decode
    logic        hit, wr, rd, sel_all;
    logic [1:0]  off;
    logic [31:0] rd_word, status_word;
    logic [7:0]  m2c_count8, c2m_count8;
    logic        unused_adr;

    // FIFO state flags and transfer strobes
    logic m2c_empty, m2c_full, c2m_empty, c2m_full;
    logic tx_wr, m2c_push, m2c_pop, ovf_set;
    logic rx_rd, c2m_push, c2m_pop, unf_set;
    logic w1c_wr, ctrl_wr;

    // The ack term blocks a second hit in the ack cycle, giving one ack every two cycles
    assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~wbs_ack_o;
    assign off     = wbs_adr_i[3:2];
    assign wr      = hit & wbs_we_i;
    assign rd      = hit & ~wbs_we_i;
    assign sel_all = (wbs_sel_i == 4'hF);
    assign unused_adr = ^wbs_adr_i[1:0];

    assign m2c_empty = (m2c_count == '0);
    assign m2c_full  = (m2c_count == FULL_COUNT);
    assign c2m_empty = (c2m_count == '0);
    assign c2m_full  = (c2m_count == FULL_COUNT);

    // Full/empty are taken from the pre-edge state, so a same-cycle pop never frees room for a push
    assign tx_wr    = wr & (off == 2'd0) & sel_all;
    assign m2c_push = tx_wr & ~m2c_full;
    assign ovf_set  = tx_wr & m2c_full;
    assign m2c_pop  = ~m2c_empty & m2c_ready;

    assign rx_rd    = rd & (off == 2'd1);
    assign c2m_pop  = rx_rd & ~c2m_empty;
    assign unf_set  = rx_rd & c2m_empty;
    assign c2m_push = c2m_valid & ~c2m_full;

    // Status and control live in byte lane 0, so only sel[0] gates them
    assign w1c_wr  = wr & (off == 2'd2) & wbs_sel_i[0];
    assign ctrl_wr = wr & (off == 2'd3) & wbs_sel_i[0];

    assign m2c_count8  = 8'(m2c_count);
    assign c2m_count8  = 8'(c2m_count);
    assign status_word = {8'h00, c2m_count8, m2c_count8, 2'b00, unf, ovf,
                          c2m_full, c2m_empty, m2c_full, m2c_empty};

    assign m2c_valid = ~m2c_empty;
    assign m2c_data  = m2c_empty ? 32'h0 : m2c_mem[m2c_rptr];
    assign c2m_ready = ~c2m_full;

    // Read mux for the register window
    always_comb begin
        rd_word = '0;
        case (off)
            2'd0:    rd_word = '0;
            2'd1:    rd_word = c2m_empty ? 32'h0 : c2m_mem[c2m_rptr];
            2'd2:    rd_word = status_word;
            default: rd_word = {30'b0, txie, rxie};
        endcase
    end

    // Wishbone ack and registered read data, zero outside ack cycles
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= hit;
            wbs_dat_o <= rd ? rd_word : 32'h0;
        end
    end

    // m2c pointers and occupancy
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            m2c_wptr  <= '0;
            m2c_rptr  <= '0;
            m2c_count <= '0;
        end else begin
            if (m2c_push) m2c_wptr <= m2c_wptr + AW'(1);
            if (m2c_pop)  m2c_rptr <= m2c_rptr + AW'(1);
            if (m2c_push & ~m2c_pop)      m2c_count <= m2c_count + CW'(1);
            else if (~m2c_push & m2c_pop) m2c_count <= m2c_count - CW'(1);
        end
    end

    // m2c storage; contents need no reset since the count gates every read
    always_ff @(posedge wb_clk_i) begin
        if (m2c_push) m2c_mem[m2c_wptr] <= wbs_dat_i;
    end

    // c2m pointers and occupancy
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            c2m_wptr  <= '0;
            c2m_rptr  <= '0;
            c2m_count <= '0;
        end else begin
            if (c2m_push) c2m_wptr <= c2m_wptr + AW'(1);
            if (c2m_pop)  c2m_rptr <= c2m_rptr + AW'(1);
            if (c2m_push & ~c2m_pop)      c2m_count <= c2m_count + CW'(1);
            else if (~c2m_push & c2m_pop) c2m_count <= c2m_count - CW'(1);
        end
    end

    // c2m storage
    always_ff @(posedge wb_clk_i) begin
        if (c2m_push) c2m_mem[c2m_wptr] <= c2m_data;
    end

    // Sticky OVF/UNF with write-one-to-clear (a new set beats a clear) and CTRL enables
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ovf  <= 1'b0;
            unf  <= 1'b0;
            rxie <= 1'b0;
            txie <= 1'b0;
        end else begin
            ovf <= ovf_set | (ovf & ~(w1c_wr & wbs_dat_i[4]));
            unf <= unf_set | (unf & ~(w1c_wr & wbs_dat_i[5]));
            if (ctrl_wr) begin
                rxie <= wbs_dat_i[0];
                txie <= wbs_dat_i[1];
            end
        end
    end

    // Interrupt is registered from current state, lagging any change by one cycle
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) irq <= 1'b0;
        else          irq <= (rxie & ~c2m_empty) | (txie & m2c_empty);
    end

endmodule

// File: tb/tb_qf105_wb_mailbox.sv
// tb/tb_qf105_wb_mailbox.sv - directed bench for qf105_wb_mailbox with a queue-based mailbox model
module tb_qf105_wb_mailbox;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 4;
    localparam logic [31:0] A_TX  = BASE;
    localparam logic [31:0] A_RX  = BASE + 32'h4;
    localparam logic [31:0] A_ST  = BASE + 32'h8;
    localparam logic [31:0] A_CT  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat = '0, adr = '0;
    logic        ack;
    logic [31:0] rdat;
    logic [31:0] m2c_data;
    logic        m2c_valid;
    logic        m2c_ready = 1'b0;
    logic [31:0] c2m_data = '0;
    logic        c2m_valid = 1'b0;
    logic        c2m_ready;
    logic        irq;

    always #5 clk = ~clk;

    qf105_wb_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_dat_i(dat),
        .wbs_adr_i(adr),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .m2c_data (m2c_data),
        .m2c_valid(m2c_valid),
        .m2c_ready(m2c_ready),
        .c2m_data (c2m_data),
        .c2m_valid(c2m_valid),
        .c2m_ready(c2m_ready),
        .irq      (irq)
    );

    int vectors = 0;
    int miscompares = 0;
    bit checking = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Mailbox model: two word queues, sticky flags, enables, and the registered bus outputs
    logic [31:0] mq[$];
    logic [31:0] cq[$];
    bit          m_ovf = 0, m_unf = 0;
    bit [1:0]    m_ctrl = 0;
    logic        m_ack = 0, m_irq = 0;
    logic [31:0] m_dat = '0;

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = (mq.size() == 0);
        s[1]     = (mq.size() == DEPTH);
        s[2]     = (cq.size() == 0);
        s[3]     = (cq.size() == DEPTH);
        s[4]     = m_ovf;
        s[5]     = m_unf;
        s[15:8]  = 8'(mq.size());
        s[23:16] = 8'(cq.size());
        return s;
    endfunction

    always @(posedge clk) begin : model
        int          msz, csz;
        logic        hit_now, push_m, irq_next;
        logic [31:0] rword;
        if (rst) begin
            mq.delete();
            cq.delete();
            m_ovf = 0; m_unf = 0; m_ctrl = 0;
            m_ack = 0; m_dat = '0; m_irq = 0;
        end else begin
            msz      = mq.size();
            csz      = cq.size();
            irq_next = (m_ctrl[0] && csz > 0) || (m_ctrl[1] && msz == 0);
            hit_now  = cyc && stb && ((adr & 32'hFFFF_FFF0) == BASE) && !m_ack;
            rword    = '0;
            push_m   = 0;
            if (hit_now && !we) begin
                case (adr[3:2])
                    2'd1: begin
                        if (csz == 0) m_unf = 1;
                        else rword = cq.pop_front();
                    end
                    2'd2:    rword = model_status();
                    2'd3:    rword = {30'b0, m_ctrl};
                    default: rword = '0;
                endcase
            end else if (hit_now && we) begin
                case (adr[3:2])
                    2'd0: if (sel == 4'hF) begin
                        if (msz == DEPTH) m_ovf = 1;
                        else push_m = 1;
                    end
                    2'd2: if (sel[0]) begin
                        if (dat[4]) m_ovf = 0;
                        if (dat[5]) m_unf = 0;
                    end
                    2'd3: if (sel[0]) m_ctrl = dat[1:0];
                    default: ;
                endcase
            end
            if (m2c_ready && msz > 0) void'(mq.pop_front());
            if (push_m) mq.push_back(dat);
            if (c2m_valid && csz < DEPTH) cq.push_back(c2m_data);
            m_ack = hit_now;
            m_dat = rword;
            m_irq = irq_next;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (checking) begin
            chk("ack", 32'(ack), 32'(m_ack));
            chk("rdata", rdat, m_dat);
            chk("m2c_valid", 32'(m2c_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) chk("m2c_data", m2c_data, mq[0]);
            else                chk("m2c_data", m2c_data, 32'h0);
            chk("c2m_ready", 32'(c2m_ready), 32'(cq.size() < DEPTH));
            chk("irq", 32'(irq), 32'(m_irq));
        end
    end

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic cpush, input logic [31:0] cdat, input logic mpop,
                       output logic [31:0] rdata, output logic got_ack);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
        c2m_valid = cpush; c2m_data = cdat; m2c_ready = mpop;
        @(negedge clk);
        rdata = rdat;
        got_ack = ack;
        cyc = 0; stb = 0; we = 0; c2m_valid = 0; m2c_ready = 0;
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        logic        k;
        bus(1'b1, a, d, s, 1'b0, 32'h0, 1'b0, r, k);
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] r);
        logic k;
        bus(1'b0, a, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, r, k);
    endtask

    task automatic core_push(input logic [31:0] d);
        @(negedge clk);
        c2m_valid = 1; c2m_data = d;
        @(negedge clk);
        c2m_valid = 0;
    endtask

    task automatic fill_m2c();
        for (int i = 0; i < DEPTH; i++) wb_wr(A_TX, 32'hA5A5_0001 + i, 4'hF);
    endtask

    task automatic drain_m2c();
        @(negedge clk);
        m2c_ready = 1;
        repeat (DEPTH) @(negedge clk);
        m2c_ready = 0;
    endtask

    initial begin
        logic [31:0] r;
        logic        k;
        int          acks;

        repeat (3) @(negedge clk);
        checking = 1;
        #2 rst = 0;
        wb_rd(A_ST, r);            chk("reset_status", r, 32'h0000_0005);
        chk("reset_c2m_ready", 32'(c2m_ready), 32'h1);
        chk("reset_irq", 32'(irq), 32'h0);

        // Reset lands in the middle of a TXDATA write
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = A_TX; dat = 32'hDEAD_BEEF; sel = 4'hF;
        #2 rst = 1;
        @(negedge clk);
        chk("rst_no_ack", 32'(ack), 32'h0);
        cyc = 0; stb = 0; we = 0;
        #2 rst = 0;
        wb_rd(A_ST, r);            chk("rst_mid_status", r, 32'h0000_0005);

        // Management to core, overflow, in-order delivery
        fill_m2c();
        wb_rd(A_ST, r);            chk("m2c_full_status", r, 32'h0000_0406);
        wb_wr(A_TX, 32'hA5A5_0005, 4'hF);
        wb_rd(A_ST, r);            chk("m2c_ovf_status", r, 32'h0000_0416);
        @(negedge clk);
        m2c_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("m2c_order", m2c_data, 32'hA5A5_0001 + i);
            @(negedge clk);
        end
        m2c_ready = 0;
        wb_wr(A_ST, 32'h30, 4'hF);
        wb_rd(A_ST, r);            chk("ovf_cleared", r, 32'h0000_0005);

        // Core to management, underflow, W1C
        core_push(32'h1234_5678);
        bus(1'b0, A_RX, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, r, k);
        chk("rx_data", r, 32'h1234_5678);
        chk("rx_ack", 32'(k), 32'h1);
        wb_rd(A_RX, r);            chk("rx_empty_data", r, 32'h0);
        wb_rd(A_ST, r);            chk("unf_status", r, 32'h0000_0025);
        wb_wr(A_ST, 32'h30, 4'hF);
        wb_rd(A_ST, r);            chk("unf_cleared", r, 32'h0000_0005);

        // Interrupts
        wb_wr(A_CT, 32'h1, 4'hF);
        core_push(32'hC0DE_0001);
        chk("irq_push_edge", 32'(irq), 32'h0);
        @(negedge clk);
        chk("irq_rx_high", 32'(irq), 32'h1);
        wb_rd(A_RX, r);            chk("irq_rx_word", r, 32'hC0DE_0001);
        @(negedge clk);
        chk("irq_rx_low", 32'(irq), 32'h0);
        wb_wr(A_CT, 32'h2, 4'hF);
        @(negedge clk);
        chk("irq_tx_high", 32'(irq), 32'h1);
        wb_rd(A_CT, r);            chk("ctrl_read", r, 32'h2);
        wb_wr(A_CT, 32'h0, 4'hF);

        // Full m2c: TXDATA write and core pop on the same edge
        fill_m2c();
        bus(1'b1, A_TX, 32'h0BAD_0BAD, 4'hF, 1'b0, 32'h0, 1'b1, r, k);
        wb_rd(A_ST, r);            chk("m2c_sim_status", r, 32'h0000_0314);
        drain_m2c();
        wb_wr(A_ST, 32'h10, 4'hF);

        // c2m with one entry: RXDATA pop and core push on the same edge
        core_push(32'h1111_1111);
        bus(1'b0, A_RX, 32'h0, 4'hF, 1'b1, 32'h2222_2222, 1'b0, r, k);
        chk("c2m_sim_word", r, 32'h1111_1111);
        wb_rd(A_ST, r);            chk("c2m_sim_status", r, 32'h0001_0001);
        wb_rd(A_RX, r);            chk("c2m_sim_next", r, 32'h2222_2222);

        // c2m fills and back-pressures the core
        @(negedge clk);
        c2m_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            c2m_data = 32'h100 + i;
            @(negedge clk);
        end
        chk("c2m_ready_full", 32'(c2m_ready), 32'h0);
        c2m_data = 32'h1FF;
        @(negedge clk);
        c2m_valid = 0;
        wb_rd(A_ST, r);            chk("c2m_full_status", r, 32'h0004_0009);
        for (int i = 0; i < DEPTH; i++) begin
            wb_rd(A_RX, r);        chk("c2m_drain", r, 32'h100 + i);
        end

        // Decode and byte selects
        bus(1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, r, k);
        chk("miss_no_ack", 32'(k), 32'h0);
        wb_wr(A_TX, 32'h5555_AAAA, 4'h3);
        wb_rd(A_ST, r);            chk("partial_sel_no_push", r, 32'h0000_0005);
        fill_m2c();
        wb_wr(A_TX, 32'h5555_AAAA, 4'hF);
        drain_m2c();
        wb_rd(A_ST, r);            chk("ovf_before_lane_clear", r, 32'h0000_0015);
        wb_wr(A_ST, 32'h10, 4'h1);
        wb_rd(A_ST, r);            chk("ovf_lane0_clear", r, 32'h0000_0005);

        // Master holding strobe sees alternating acks
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = A_ST; sel = 4'hF;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            acks += int'(ack);
        end
        cyc = 0; stb = 0;
        chk("b2b_acks", 32'(acks), 32'd2);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qf105_wb_mailbox.md
# qf105_wb_mailbox

Wishbone slave that connects the Caravel management SoC Wishbone port (wbs_*) to the QF105 core through two 32-bit word FIFOs:
- mgmt-to-core (m2c)
- core-to-mgmt (c2m)

It sits between the user_project_wrapper Wishbone pins and the QF105 core stream ports. It drives one user interrupt so management firmware can exchange messages with the core without polling.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000, byte address of the 16-byte register window; bits [3:0] must be zero.
- DEPTH, 4, entries per FIFO; must be a power of two, 2..128.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- m2c_data  out  32  head of the m2c FIFO.
- m2c_valid  out  1  m2c FIFO not empty.
- m2c_ready  in  1  core accepts m2c_data.
- c2m_data  in  32  word from core.
- c2m_valid  in  1  core offers c2m_data.
- c2m_ready  out  1  c2m FIFO not full.
- irq  out  1  interrupt, drives user_irq[0].

## Operation
- **Address hit:** wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & !wbs_ack_o. Misses are never acked.
- **Register map** (offset = wbs_adr_i[3:2]):
  - 0 TXDATA (W): push wbs_dat_i into m2c. Reads return 0.
  - 1 RXDATA (R): return the c2m head and pop it. Writes are ignored.
  - 2 STATUS (R, W1C):
    - [0] m2c_empty, [1] m2c_full, [2] c2m_empty, [3] c2m_full.
    - [4] OVF sticky, [5] UNF sticky.
    - [15:8] m2c count, [23:16] c2m count; other bits 0.
    - Writing 1 to bit 4 or 5 clears that bit; all other bits are read-only.
  - 3 CTRL (RW):
    - [0] RXIE: irq when c2m is non-empty.
    - [1] TXIE: irq when m2c is empty.
    - Other bits read 0.
- **Byte selects:** a write takes effect only when wbs_sel_i == 4'hF. Otherwise the write is acked and has no effect, except that W1C bits and CTRL bits do update if the byte lane holding them is selected. Reads ignore wbs_sel_i.
- **TXDATA push:** if m2c is full, the word is dropped and OVF is set.
- **RXDATA pop:** if c2m is empty, the read returns 0, nothing pops, and UNF is set.
- **Core side:**
  - m2c pops on m2c_valid & m2c_ready; m2c_data is the head (first-word fall-through).
  - c2m pushes on c2m_valid & c2m_ready.
- **FIFO counters:** read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits, zero-extended into its STATUS field.
- **Simultaneous events:**
  - A push and a pop on the same FIFO in the same cycle leave the count unchanged and both complete.
  - Full is evaluated before the same-cycle pop: a push into a full FIFO is rejected even if a pop occurs in that cycle. This gives OVF on m2c, and c2m_ready stays low.
  - Empty is evaluated before the same-cycle push: a pop from an empty FIFO fails (UNF on c2m; m2c_valid low) even if a push occurs in that cycle.
  - A W1C clear and a new OVF/UNF set in the same cycle: the set wins.
- **irq:** registered; irq <= (RXIE & !c2m_empty) | (TXIE & m2c_empty).

## Timing
- **Ack:**
  - wbs_ack_o rises on the edge after a hit and lasts exactly 1 cycle.
  - A master holding stb gets one ack every 2 cycles.
- **Read data:**
  - wbs_dat_o is registered on the same edge as ack and is 0 in every cycle without ack.
  - The RXDATA pop happens on that same edge.
- **Write effects:**
  - Writes commit on the edge ack rises.
  - A TXDATA push makes m2c_valid high during the ack cycle when m2c was empty.
  - A c2m push is visible in STATUS and RXDATA one cycle after the handshake edge.
- **irq:** follows the FIFO or CTRL state change by 1 cycle.
- **Reset values** (asynchronous, while wb_rst_i is high and after it falls):
  - Outputs: wbs_ack_o=0, wbs_dat_o=0, m2c_valid=0, m2c_data=0, c2m_ready=1, irq=0.
  - Internal state: FIFOs empty, CTRL=0, OVF=UNF=0.
- **Reset mid-operation:** a transaction in flight is dropped without ack and FIFO contents are discarded; the master must retry.

## Test plan
- **Reset:** assert wb_rst_i mid-write to TXDATA -> no ack, STATUS reads 0x00000005 after release, c2m_ready=1, irq=0.
- **Mgmt to core:** write 0xA5A5_0001..0xA5A5_0004 to TXDATA (DEPTH=4) with m2c_ready=0 -> STATUS=0x00000406 (m2c_full, c2m_empty, count 4). A 5th write sets OVF (STATUS bit4). Raising m2c_ready then delivers the four words in order, one per cycle.
- **Core to mgmt:** core pushes 0x1234_5678 -> RXDATA returns 0x1234_5678 with ack 1 cycle after stb. A second read returns 0 and sets UNF. Writing 0x30 to STATUS clears OVF and UNF.
- **Interrupts:** CTRL=0x1, core pushes one word -> irq high 1 cycle after the push edge, low 1 cycle after the RXDATA pop. CTRL=0x2 with m2c empty -> irq=1.
- **Simultaneous events:**
  - m2c full, TXDATA write and core pop on the same edge -> write dropped, OVF=1, count 3.
  - c2m with 1 entry, RXDATA pop and core push on the same edge -> count stays 1, data order preserved.
- **Decode:**
  - Access at BASE_ADDR+0x10 -> no ack.
  - TXDATA write with wbs_sel_i=4'h3 -> acked, no push.
  - STATUS write of 0x10 with wbs_sel_i=4'h1 while OVF=1 -> OVF cleared.
  - Back-to-back stb -> acks on alternating cycles.
